sar_search_4: RTL

//  - Successive-approximation search controller. It drives the B side of an external combinational

---
 rtl/sar_pkg.sv | 12 +
 rtl/sar_search_4_if.sv | 26 ++
 rtl/sar_flag_chk.sv | 20 ++
 rtl/sar_search_4.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared state encoding and default width for the successive-approximation search block.
package sar_pkg;

    localparam int unsigned SAR_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : sar_pkg

// File: rtl/sar_search_4_if.sv
// Search request/result and comparator signals for sar_search_4.
// master: the search controller (drives probe, collects flags).
// slave : the requester plus the external comparator (drives start and flags).
interface sar_search_4_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             cmp_lt;
    logic [WIDTH-1:0] probe;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        input  start, cmp_gt, cmp_eq, cmp_lt,
        output probe, busy, done, result, err
    );

    modport slave (
        output start, cmp_gt, cmp_eq, cmp_lt,
        input  probe, busy, done, result, err
    );
endinterface : sar_search_4_if

// File: rtl/sar_flag_chk.sv
// Comparator flag sanity check: exactly one of {gt, eq, lt} must be set.
module sar_flag_chk (
    input  logic gt,
    input  logic eq,
    input  logic lt,
    output logic one_hot_ok
);

    // Accept only the three legal single-flag patterns.
    always_comb begin
        one_hot_ok = 1'b0;
        case ({gt, eq, lt})
            3'b100,
            3'b010,
            3'b001:  one_hot_ok = 1'b1;
            default: one_hot_ok = 1'b0;
        endcase
    end

endmodule : sar_flag_chk

// File: rtl/sar_search_4.sv
// Successive-approximation search controller: walks probe MSB-first against an
// external combinational comparator until the unknown A is found.
// Optional feature macro: SAR_EARLY_EXIT_EN (finish as soon as the comparator reports equal).
module sar_search_4
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = SAR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    sar_search_4_if.master  bus
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [IW-1:0]    idx;

    logic [WIDTH-1:0] probe_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             err_q;

    logic             flags_ok;
    logic             keep;
    logic             eq_exit;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] acc_dec;
    logic [IW-1:0]    idx_dn;
    logic [WIDTH-1:0] probe_nxt;

    sar_flag_chk u_flag_chk (
        .gt         (bus.cmp_gt),
        .eq         (bus.cmp_eq),
        .lt         (bus.cmp_lt),
        .one_hot_ok (flags_ok)
    );

    // Per-cycle bit decision and the probe that follows it.
    always_comb begin
        keep      = 1'b0;
        eq_exit   = 1'b0;
        trial     = acc | (ONE << idx);
`ifdef SAR_EARLY_EXIT_EN
        keep      = bus.cmp_gt;
        eq_exit   = bus.cmp_eq;
`else
        keep      = bus.cmp_gt | bus.cmp_eq;
        eq_exit   = 1'b0;
`endif
        // acc never has bit idx set before the decision, so "clear" means keep acc as is.
        acc_dec   = keep ? trial : acc;
        idx_dn    = idx - IW'(1);
        probe_nxt = acc_dec | (ONE << idx_dn);
    end

    // Search FSM; probe/busy/done are registered alongside the state they reflect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            idx      <= IDX_TOP;
            probe_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        state   <= S_RUN;
                        acc     <= '0;
                        idx     <= IDX_TOP;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        probe_q <= ONE << IDX_TOP;
                    end else begin
                        busy_q  <= 1'b0;
                        probe_q <= '0;
                    end
                end
                S_RUN: begin
                    if (!flags_ok) begin
                        state    <= S_DONE;
                        err_q    <= 1'b1;
                        result_q <= '0;
                        done_q   <= 1'b1;
                        probe_q  <= '0;
                    end else if (eq_exit) begin
                        state    <= S_DONE;
                        result_q <= trial;
                        done_q   <= 1'b1;
                        probe_q  <= '0;
                    end else if (idx == '0) begin
                        state    <= S_DONE;
                        acc      <= acc_dec;
                        result_q <= acc_dec;
                        done_q   <= 1'b1;
                        probe_q  <= '0;
                    end else begin
                        acc      <= acc_dec;
                        idx      <= idx_dn;
                        probe_q  <= probe_nxt;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    probe_q <= '0;
                end
                default: begin
                    state   <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    probe_q <= '0;
                end
            endcase
        end
    end

    assign bus.probe  = probe_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule : sar_search_4
